// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between inst_sram and data_sram; an in-order tag FIFO steers responses.
// Optional build macro SRAM_ARB_ROUND_ROBIN_EN replaces fixed data priority with round-robin.
module sram_port_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_sram_req,
  input  logic             inst_sram_wr,
  input  logic [1:0]       inst_sram_size,
  input  logic [3:0]       inst_sram_wstrb,
  input  logic [31:0]      inst_sram_addr,
  input  logic [31:0]      inst_sram_wdata,
  output logic             inst_sram_addr_ok,
  output logic             inst_sram_data_ok,
  output logic [31:0]      inst_sram_rdata,
  input  logic             data_sram_req,
  input  logic             data_sram_wr,
  input  logic [1:0]       data_sram_size,
  input  logic [3:0]       data_sram_wstrb,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic             data_sram_addr_ok,
  output logic             data_sram_data_ok,
  output logic [31:0]      data_sram_rdata,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_addr_ok,
  input  logic             mem_data_ok,
  input  logic [31:0]      mem_rdata,
  output logic [PTR_W:0]   outstanding,
  output logic             proto_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   count;
  logic             tag_mem [DEPTH];
  logic             full;
  logic             prio_d;
  logic             gnt_d;
  logic             gnt_i;
  logic             push;
  logic             pop;
  logic             rsp_tag;

  assign full  = (count == FULL_CNT);
  assign gnt_d = data_sram_req & (~inst_sram_req | prio_d);
  assign gnt_i = inst_sram_req & ~gnt_d;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic rr_last;

  // rr_last remembers who won the last committed request so the other side wins next
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_last <= 1'b0;
    else if (push)
      rr_last <= gnt_d;
  end

  assign prio_d = ~rr_last;
`else
  assign prio_d = 1'b1;
`endif

  // Request side: fields follow the granted master, defaulting to data when idle
  assign mem_req   = (inst_sram_req | data_sram_req) & ~full;
  assign mem_wr    = gnt_i ? inst_sram_wr    : data_sram_wr;
  assign mem_size  = gnt_i ? inst_sram_size  : data_sram_size;
  assign mem_wstrb = gnt_i ? inst_sram_wstrb : data_sram_wstrb;
  assign mem_addr  = gnt_i ? inst_sram_addr  : data_sram_addr;
  assign mem_wdata = gnt_i ? inst_sram_wdata : data_sram_wdata;

  assign inst_sram_addr_ok = gnt_i & mem_addr_ok & ~full;
  assign data_sram_addr_ok = gnt_d & mem_addr_ok & ~full;

  assign push = mem_req & mem_addr_ok;
  assign pop  = mem_data_ok & (count != '0);

  // Response side: the oldest tag decides which requester sees data_ok
  assign rsp_tag           = tag_mem[rptr];
  assign inst_sram_data_ok = pop & ~rsp_tag;
  assign data_sram_data_ok = pop & rsp_tag;
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  assign outstanding = count;

  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wptr] <= gnt_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem_data_ok && (count == '0))
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter; responses are checked by a queue-based scoreboard monitor.
module tb_sram_port_arbiter;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  outstanding;
  logic        proto_err;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q [$];

  localparam logic [31:0] IADDR = 32'h1c00_0000;
  localparam logic [31:0] DADDR = 32'h8000_0000;

  sram_port_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every data_ok pulse must match the oldest expected response
  always @(negedge clk) begin
    if (!reset && (inst_sram_data_ok || data_sram_data_ok)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: inst_ok=%0b data_ok=%0b with nothing expected at %0t",
                 inst_sram_data_ok, data_sram_data_ok, $time);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("resp_owner", {30'd0, data_sram_data_ok, inst_sram_data_ok},
              e[32] ? 32'd2 : 32'd1);
        check("resp_rdata", e[32] ? data_sram_rdata : inst_sram_rdata, e[31:0]);
      end
    end
  end

  initial begin
    logic gq [$];
    logic exp_d;
    logic prev_d;

    reset = 1'b1;
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
    inst_sram_wstrb = 4'h0; inst_sram_addr = IADDR; inst_sram_wdata = 32'h0;
    data_sram_req = 1'b0; data_sram_wr = 1'b1; data_sram_size = 2'd2;
    data_sram_wstrb = 4'hf; data_sram_addr = DADDR; data_sram_wdata = 32'hdead_beef;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    repeat (2) cyc;
    reset = 1'b0;
    #1;
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_proto_err", 32'(proto_err), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 0);
    check("rst_data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 0);
    cyc;

    // T1 single inst read
    inst_sram_req = 1'b1;
    #1;
    check("t1_mem_req", 32'(mem_req), 1);
    check("t1_mem_addr", mem_addr, IADDR);
    check("t1_mem_wr", 32'(mem_wr), 0);
    check("t1_wait_addr_ok", 32'(inst_sram_addr_ok), 0);
    cyc;
    mem_addr_ok = 1'b1;
    #1;
    check("t1_inst_addr_ok", 32'(inst_sram_addr_ok), 1);
    check("t1_data_addr_ok", 32'(data_sram_addr_ok), 0);
    cyc;
    inst_sram_req = 1'b0; mem_addr_ok = 1'b0;
    #1;
    check("t1_outstanding", 32'(outstanding), 1);
    check("t1_idle_fields", mem_addr, DADDR);
    cyc;
    mem_data_ok = 1'b1; mem_rdata = 32'h0280_0c0c;
    exp_q.push_back({1'b0, 32'h0280_0c0c});
    #1;
    check("t1_data_data_ok", 32'(data_sram_data_ok), 0);
    cyc;
    mem_data_ok = 1'b0;
    #1;
    check("t1_drained", 32'(outstanding), 0);
    cyc;

    // T2/T3 contention and fill to DEPTH
    inst_sram_req = 1'b1; data_sram_req = 1'b1; mem_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = RR ? ((k % 2) == 0) : 1'b1;
      #1;
      check("t2_gnt_d", 32'(data_sram_addr_ok), 32'(exp_d));
      check("t2_gnt_i", 32'(inst_sram_addr_ok), 32'(!exp_d));
      check("t2_mem_addr", mem_addr, exp_d ? DADDR : IADDR);
      gq.push_back(exp_d);
      cyc;
    end
    #1;
    check("t3_full_outstanding", 32'(outstanding), 4);
    check("t3_full_mem_req", 32'(mem_req), 0);
    check("t3_full_addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 0);
    cyc;
    data_sram_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h100;
    exp_q.push_back({gq.pop_front(), 32'h100});
    #1;
    check("t3_pop_full_no_accept", 32'(inst_sram_addr_ok), 0);
    cyc;
    mem_data_ok = 1'b0;
    #1;
    check("t3_after_pop", 32'(outstanding), 3);
    check("t2_inst_after_data", 32'(inst_sram_addr_ok), 1);
    gq.push_back(1'b0);
    cyc;
    inst_sram_req = 1'b0; mem_addr_ok = 1'b0;
    #1;
    check("t3_refill", 32'(outstanding), 4);
    for (int k = 0; k < 4; k++) begin
      mem_data_ok = 1'b1; mem_rdata = 32'h101 + 32'(k);
      exp_q.push_back({gq.pop_front(), 32'h101 + 32'(k)});
      cyc;
    end
    mem_data_ok = 1'b0;
    #1;
    check("t2_drained", 32'(outstanding), 0);
    cyc;

    // T4 interleaved order with a same-cycle push and pop
    inst_sram_req = 1'b1; mem_addr_ok = 1'b1;
    #1;
    check("t4_acc_inst0", 32'(inst_sram_addr_ok), 1);
    cyc;
    inst_sram_req = 1'b0; data_sram_req = 1'b1;
    mem_data_ok = 1'b1; mem_rdata = 32'hA;
    exp_q.push_back({1'b0, 32'hA});
    #1;
    check("t4_acc_data", 32'(data_sram_addr_ok), 1);
    cyc;
    data_sram_req = 1'b0; inst_sram_req = 1'b1; mem_data_ok = 1'b0;
    #1;
    check("t4_pushpop_count", 32'(outstanding), 1);
    check("t4_acc_inst1", 32'(inst_sram_addr_ok), 1);
    cyc;
    inst_sram_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'hB;
    exp_q.push_back({1'b1, 32'hB});
    #1;
    check("t4_two_inflight", 32'(outstanding), 2);
    cyc;
    mem_rdata = 32'hC;
    exp_q.push_back({1'b0, 32'hC});
    cyc;
    mem_data_ok = 1'b0;
    #1;
    check("t4_drained", 32'(outstanding), 0);
    cyc;

    // T5 stray response, then reset with requests in flight
    mem_data_ok = 1'b1; mem_rdata = 32'hbad;
    #1;
    check("t5_err_not_yet", 32'(proto_err), 0);
    cyc;
    mem_data_ok = 1'b0;
    #1;
    check("t5_proto_err", 32'(proto_err), 1);
    check("t5_outstanding", 32'(outstanding), 0);
    cyc;
    inst_sram_req = 1'b1; mem_addr_ok = 1'b1;
    cyc;
    cyc;
    inst_sram_req = 1'b0; mem_addr_ok = 1'b0;
    #1;
    check("t5_two_inflight", 32'(outstanding), 2);
    reset = 1'b1;
    #1;
    check("t5_rst_outstanding", 32'(outstanding), 0);
    check("t5_rst_proto_err", 32'(proto_err), 0);
    cyc;
    reset = 1'b0;
    cyc;
    mem_data_ok = 1'b1; mem_rdata = 32'hbad;
    cyc;
    mem_data_ok = 1'b0;
    #1;
    check("t5_stale_proto_err", 32'(proto_err), 1);
    check("t5_stale_outstanding", 32'(outstanding), 0);
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    cyc;

    // T6 round-robin alternation, responses keep the FIFO from filling
    if (RR) begin
      inst_sram_req = 1'b1; data_sram_req = 1'b1; mem_addr_ok = 1'b1;
      prev_d = 1'b0;
      for (int k = 0; k < 6; k++) begin
        exp_d = ((k % 2) == 0);
        if (k > 0) begin
          mem_data_ok = 1'b1; mem_rdata = 32'h200 + 32'(k);
          exp_q.push_back({prev_d, 32'h200 + 32'(k)});
        end
        #1;
        check("t6_rr_gnt_d", 32'(data_sram_addr_ok), 32'(exp_d));
        check("t6_rr_gnt_i", 32'(inst_sram_addr_ok), 32'(!exp_d));
        prev_d = exp_d;
        cyc;
      end
      inst_sram_req = 1'b0; data_sram_req = 1'b0; mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1; mem_rdata = 32'h206;
      exp_q.push_back({prev_d, 32'h206});
      cyc;
      mem_data_ok = 1'b0;
      #1;
      check("t6_drained", 32'(outstanding), 0);
      cyc;
    end

    cyc;
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
